// File: rtl/tile_pixel_renderer.sv
// ---------------------------------------------------------------------------
// tile_pixel_renderer
//   Turns the background tile index for the current pixel into 24-bit RGB.
//   The pipeline has three stages, so the output is 3 Clk after the input:
//     s1 : register tile index, texel coords (DrawX/DrawY low bits), valid, Gen_Done
//     s2 : synchronous texel ROM read for tiles 1-4, tile class carried alongside
//     s3 : palette / colour resolve into the output registers
//   The texel image for tiles 1-4 is a built-in constant pattern. It is a
//   4-bit palette index per texel, with index 0 meaning transparent.
//
//   Optional feature: define TILE_ANIM_EN to enable the frame counter and the
//   anim_phase toggle. With anim_phase=1, tile 1 is drawn with tx mirrored.
//
// Ports
//   Clk, Reset_n              pixel clock, async active-low reset
//   Gen_Done                  map generation complete (sampled each cycle)
//   pix_valid, DrawX, DrawY   pixel position and active-area flag
//   tilenumber                tile index for (DrawX,DrawY), same cycle
//   Red, Green, Blue          registered pixel colour
//   rgb_valid                 pix_valid delayed 3 cycles
//   anim_phase                animation phase (0 without TILE_ANIM_EN)
// ---------------------------------------------------------------------------
module tile_pixel_renderer #(
    parameter logic [23:0] BG_RGB      = 24'h228B22,
    parameter logic [23:0] BORDER_RGB  = 24'h404040,
    parameter logic [23:0] STONE_RGB   = 24'h808080,
    parameter int          ANIM_PERIOD = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Gen_Done,
    input  logic       pix_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [2:0] tilenumber,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       rgb_valid,
    output logic       anim_phase
);

    typedef enum logic [2:0] {
        CLS_BG     = 3'd0,
        CLS_BORDER = 3'd1,
        CLS_STONE  = 3'd2,
        CLS_TEX    = 3'd3
    } cls_e;

    // Texel image: addr = {tile-1, ty, tx}.
    // idx = (4*t + 3*ty + tx + 14) mod 16.
    function automatic logic [3:0] texel(input logic [7:0] a);
        logic [3:0] s;
        s = {a[7:6], 2'b00} + {1'b0, a[5:3]} + {a[5:3], 1'b0}
          + {1'b0, a[2:0]} + 4'd14;
        return s;
    endfunction

    function automatic logic [23:0] palette(input logic [3:0] i);
        logic [23:0] c;
        case (i)
            4'd0:    c = 24'h000000; // transparent, never displayed
            4'd1:    c = 24'h0B6623;
            4'd2:    c = 24'h1E8C3A;
            4'd3:    c = 24'h3CB04E;
            4'd4:    c = 24'h5C3A1E;
            4'd5:    c = 24'h8B5A2B;
            4'd6:    c = 24'hA0A0A0;
            4'd7:    c = 24'h6E6E6E;
            4'd8:    c = 24'h2060C0;
            4'd9:    c = 24'h3080E0;
            4'd10:   c = 24'h60A0FF;
            4'd11:   c = 24'hC2B280;
            4'd12:   c = 24'hE0D0A0;
            4'd13:   c = 24'hFFFFFF;
            4'd14:   c = 24'hFFD700;
            default: c = 24'h101010;
        endcase
        return c;
    endfunction

    // valid shift register, one bit per stage
    logic [3:1] vld_pipe;

    // ---------------- stage 1 ----------------
    logic [2:0] s1_tile, s1_tx, s1_ty;
    logic       s1_gd;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_tile     <= '0;
            s1_tx       <= '0;
            s1_ty       <= '0;
            s1_gd       <= 1'b0;
            vld_pipe[1] <= 1'b0;
        end else begin
            s1_tile     <= tilenumber;
            s1_tx       <= DrawX[2:0];
            s1_ty       <= DrawY[2:0];
            s1_gd       <= Gen_Done;
            vld_pipe[1] <= pix_valid;
        end
    end

    // ---------------- stage 2 ----------------
    logic [2:0] tx_eff;
    logic [7:0] rom_addr;
    cls_e       cls_d;
    cls_e       s2_cls;
    logic [3:0] s2_idx;
    logic       s2_gd;

    always_comb begin
        tx_eff = s1_tx;
`ifdef TILE_ANIM_EN
        // 7-tx is the bitwise inverse for a 3-bit coordinate
        if (anim_phase && s1_tile == 3'd1) tx_eff = ~s1_tx;
`endif
        // tile 4 -> 2'b00 - 1 = 2'b11, so tiles 1..4 map to slots 0..3
        rom_addr = {s1_tile[1:0] - 2'd1, s1_ty, tx_eff};
        case (s1_tile)
            3'd1, 3'd2, 3'd3, 3'd4: cls_d = CLS_TEX;
            3'd5:    cls_d = (s1_tx == 3'd0 || s1_ty == 3'd0) ? CLS_BORDER : CLS_STONE;
            default: cls_d = CLS_BG;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_cls      <= CLS_BG;
            s2_idx      <= '0;
            s2_gd       <= 1'b0;
            vld_pipe[2] <= 1'b0;
        end else begin
            s2_cls      <= cls_d;
            s2_idx      <= (cls_d == CLS_TEX) ? texel(rom_addr) : 4'd0;
            s2_gd       <= s1_gd;
            vld_pipe[2] <= vld_pipe[1];
        end
    end

    // ---------------- stage 3 ----------------
    logic [23:0] rgb_d;

    always_comb begin
        rgb_d = BG_RGB;
        if (!vld_pipe[2]) begin
            rgb_d = 24'h000000;
        end else if (!s2_gd) begin
            rgb_d = BG_RGB;
        end else begin
            case (s2_cls)
                CLS_BORDER: rgb_d = BORDER_RGB;
                CLS_STONE:  rgb_d = STONE_RGB;
                CLS_TEX:    rgb_d = (s2_idx == 4'd0) ? BG_RGB : palette(s2_idx);
                default:    rgb_d = BG_RGB;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {Red, Green, Blue} <= '0;
            vld_pipe[3]        <= 1'b0;
        end else begin
            {Red, Green, Blue} <= rgb_d;
            vld_pipe[3]        <= vld_pipe[2];
        end
    end

    assign rgb_valid = vld_pipe[3];

    // ---------------- animation ----------------
`ifdef TILE_ANIM_EN
    logic       at_origin, prev_origin, frame_start;
    logic [4:0] frame_cnt;

    // A pulse only on the first of any run of consecutive (0,0) cycles
    assign at_origin   = pix_valid && DrawX == 10'd0 && DrawY == 10'd0;
    assign frame_start = at_origin && !prev_origin;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_origin <= 1'b0;
            frame_cnt   <= '0;
            anim_phase  <= 1'b0;
        end else begin
            prev_origin <= at_origin;
            if (frame_start) begin
                if (frame_cnt == 5'(ANIM_PERIOD - 1)) begin
                    frame_cnt  <= '0;
                    anim_phase <= ~anim_phase;
                end else begin
                    frame_cnt <= frame_cnt + 5'd1;
                end
            end
        end
    end
`else
    assign anim_phase = 1'b0;

    // upper position bits and the period only matter to the animation logic
    logic unused_bits;
    assign unused_bits = ^{DrawX[9:3], DrawY[9:3], 5'(ANIM_PERIOD)};
`endif

endmodule
